// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit: one product or quotient bit per cycle,
// with a busy/done handshake for pipeline stalls and a branch-flush abort.
module muldiv_unit #(
  parameter int XLEN = 64,
  parameter int CW   = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t              r_state, w_state_next;
  logic [2:0]          r_op;
  logic [4:0]          r_rd;
  logic                r_sa, r_sb, r_b_zero, r_ovf;
  logic [XLEN-1:0]     r_a, r_b_mag;
  logic [2*XLEN-1:0]   r_acc;
  logic [CW-1:0]       r_cnt;
  logic [XLEN-1:0]     r_result;
  logic [4:0]          r_rd_out;

  logic                w_accept, w_a_signed, w_b_signed, w_sa, w_sb, w_ge;
  logic [XLEN:0]       w_sum, w_shift;
  logic [XLEN-1:0]     w_diff, w_quo, w_rem, w_fix;
  logic [2*XLEN-1:0]   w_acc_step, w_prod;

  assign w_accept   = (r_state == S_IDLE) && start && !flush;
  assign w_a_signed = !(op[0] && (op != 3'b001));
  assign w_b_signed = (op[2:1] == 2'b00) || (op[2] && !op[0]);
  assign w_sa       = w_a_signed && a[XLEN-1];
  assign w_sb       = w_b_signed && b[XLEN-1];

  // r_acc holds {high product, multiplier} for multiplies and {remainder, dividend/quotient} for divides
  assign w_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b_mag} : '0);
  assign w_shift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_ge    = w_shift >= {1'b0, r_b_mag};
  assign w_diff  = w_shift[XLEN-1:0] - r_b_mag;

  always_comb begin
    w_acc_step = {w_sum, r_acc[XLEN-1:1]};
    if (r_op[2]) begin
      w_acc_step = {(w_ge ? w_diff : w_shift[XLEN-1:0]), r_acc[XLEN-2:0], w_ge};
    end
  end

  assign w_prod = (r_sa ^ r_sb) ? -r_acc : r_acc;
  assign w_quo  = (r_sa ^ r_sb) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem  = r_sa ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_fix = '0;
    if (!r_op[2]) begin
      w_fix = (r_op[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    end else if (!r_op[1]) begin
      w_fix = r_b_zero ? '1 : (r_ovf ? r_a : w_quo);
    end else begin
      w_fix = r_b_zero ? r_a : (r_ovf ? '0 : w_rem);
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_CALC;
      S_CALC:  if (r_cnt == CW'(1)) w_state_next = S_FIX;
      S_FIX:   w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (flush) w_state_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_op     <= '0;
      r_rd     <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_b_zero <= 1'b0;
      r_ovf    <= 1'b0;
      r_a      <= '0;
      r_b_mag  <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_rd_out <= '0;
    end else begin
      if (w_accept) begin
        r_op     <= op;
        r_rd     <= rd_in;
        r_sa     <= w_sa;
        r_sb     <= w_sb;
        r_a      <= a;
        r_b_mag  <= w_sb ? -b : b;
        r_acc    <= {{XLEN{1'b0}}, (w_sa ? -a : a)};
        r_cnt    <= CW'(XLEN);
        r_b_zero <= (b == '0);
        r_ovf    <= op[2] && !op[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
      end else if (r_state == S_CALC) begin
        r_acc <= w_acc_step;
        r_cnt <= r_cnt - 1'b1;
      end
      // A flush during FIX must leave the previously reported result untouched
      if (r_state == S_FIX && !flush) begin
        r_result <= w_fix;
        r_rd_out <= r_rd;
      end
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign result = r_result;
  assign rd_out = r_rd_out;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit at XLEN=64 and XLEN=32: arithmetic reference model plus
// hand-computed literal results and latencies for each directed operation.
module tb_muldiv_unit;
  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        st    [2];
  logic [2:0]  opv   [2];
  logic [63:0] av    [2];
  logic [63:0] bv    [2];
  logic [4:0]  rdv   [2];
  logic        busy_o[2];
  logic        done_o[2];
  logic [63:0] res_o [2];
  logic [4:0]  rdo   [2];
  logic [31:0] res32;

  int          cyc = 0;
  bit          chk_en = 0;
  int          n_checks = 0;
  int          n_errs = 0;

  int          m_cnt [2];
  logic [63:0] m_res [2];
  logic [63:0] m_pend[2];
  logic [4:0]  m_rd  [2];
  logic [4:0]  m_prd [2];

  logic [63:0] lit_val[2];
  logic [4:0]  lit_rd [2];
  int          t_issue[2];

  muldiv_unit #(.XLEN(64)) u_dut64 (
    .clk(clk), .reset(rst_n), .start(st[0]), .op(opv[0]), .a(av[0]), .b(bv[0]),
    .rd_in(rdv[0]), .flush(flush), .busy(busy_o[0]), .done(done_o[0]),
    .result(res_o[0]), .rd_out(rdo[0])
  );

  muldiv_unit #(.XLEN(32)) u_dut32 (
    .clk(clk), .reset(rst_n), .start(st[1]), .op(opv[1]), .a(av[1][31:0]), .b(bv[1][31:0]),
    .rd_in(rdv[1]), .flush(flush), .busy(busy_o[1]), .done(done_o[1]),
    .result(res32), .rd_out(rdo[1])
  );
  assign res_o[1] = {32'd0, res32};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wid(input int u);
    return (u == 0) ? 64 : 32;
  endfunction

  // RISC-V M semantics evaluated with wide signed arithmetic
  function automatic logic [63:0] ref_op(input int w, input logic [2:0] op,
                                         input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] sa_v, sb_v, ua_v, ub_v, p, minv;
    logic [63:0] mask;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    ua_v = $signed({64'd0, a & mask});
    ub_v = $signed({64'd0, b & mask});
    sa_v = a[w-1] ? (ua_v - (128'sd1 <<< w)) : ua_v;
    sb_v = b[w-1] ? (ub_v - (128'sd1 <<< w)) : ub_v;
    minv = -(128'sd1 <<< (w-1));
    p = 128'sd0;
    case (op)
      3'b000: p = sa_v * sb_v;
      3'b001: p = (sa_v * sb_v) >>> w;
      3'b010: p = (sa_v * ub_v) >>> w;
      3'b011: p = (ua_v * ub_v) >>> w;
      3'b100: p = (ub_v == 0) ? -128'sd1 : ((sa_v == minv && sb_v == -128'sd1) ? sa_v : sa_v / sb_v);
      3'b101: p = (ub_v == 0) ? -128'sd1 : ua_v / ub_v;
      3'b110: p = (ub_v == 0) ? sa_v : ((sa_v == minv && sb_v == -128'sd1) ? 128'sd0 : sa_v % sb_v);
      default: p = (ub_v == 0) ? ua_v : ua_v % ub_v;
    endcase
    return p[63:0] & mask;
  endfunction

  // Cycle-level expectation: an accepted op occupies XLEN+2 busy cycles, the last being done
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (!rst_n) begin
        m_cnt[u] <= 0;
        m_res[u] <= '0;
        m_rd[u]  <= '0;
      end else if (flush) begin
        m_cnt[u] <= 0;
      end else if (m_cnt[u] == 0) begin
        if (st[u]) begin
          m_cnt[u]  <= wid(u) + 2;
          m_pend[u] <= ref_op(wid(u), opv[u], av[u], bv[u]);
          m_prd[u]  <= rdv[u];
        end
      end else begin
        m_cnt[u] <= m_cnt[u] - 1;
        if (m_cnt[u] == 2) begin
          m_res[u] <= m_pend[u];
          m_rd[u]  <= m_prd[u];
        end
      end
    end
  end

  task automatic chk(input string nm, input int u, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s unit%0d cycle %0d: got %h expected %h", nm, u, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int u = 0; u < 2; u++) begin
        chk("busy",   u, {63'd0, busy_o[u]}, {63'd0, (m_cnt[u] != 0)});
        chk("done",   u, {63'd0, done_o[u]}, {63'd0, (m_cnt[u] == 1)});
        chk("result", u, res_o[u], m_res[u]);
        chk("rd_out", u, {59'd0, rdo[u]}, {59'd0, m_rd[u]});
        if (done_o[u] && m_cnt[u] == 1) begin
          chk("lit_result",  u, res_o[u], lit_val[u]);
          chk("lit_rd",      u, {59'd0, rdo[u]}, {59'd0, lit_rd[u]});
          chk("lit_latency", u, 64'(cyc - t_issue[u]), (u == 0) ? 64'd66 : 64'd34);
          $display("unit%0d done: result=%h rd=%0d latency=%0d", u, res_o[u], rdo[u], cyc - t_issue[u]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int u, input logic [2:0] op, input logic [63:0] a,
                    input logic [63:0] b, input logic [4:0] rd, input logic [63:0] exp);
    opv[u]     = op;
    av[u]      = a;
    bv[u]      = b;
    rdv[u]     = rd;
    lit_val[u] = exp;
    lit_rd[u]  = rd;
    t_issue[u] = cyc;
    st[u]      = 1'b1;
    step();
    st[u]      = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    for (int u = 0; u < 2; u++) begin
      st[u] = 1'b0; opv[u] = '0; av[u] = '0; bv[u] = '0; rdv[u] = '0;
      lit_val[u] = '0; lit_rd[u] = '0; t_issue[u] = 0;
    end
    step();
    chk_en = 1'b1;
    step();
    rst_n = 1'b1;
    step();

    go(0, 3'b000, 64'd7, -64'sd3, 5'd1, 64'hFFFF_FFFF_FFFF_FFEB);            repeat (66) step();
    go(0, 3'b001, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd2,
       64'h4000_0000_0000_0000);                                             repeat (66) step();
    go(0, 3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3,
       64'hFFFF_FFFF_FFFF_FFFE);                                             repeat (66) step();
    go(0, 3'b010, -64'sd1, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF);            repeat (66) step();
    go(0, 3'b100, -64'sd20, 64'd3, 5'd5, 64'hFFFF_FFFF_FFFF_FFFA);           repeat (66) step();
    go(0, 3'b110, -64'sd20, 64'd3, 5'd6, 64'hFFFF_FFFF_FFFF_FFFE);           repeat (66) step();
    go(0, 3'b101, 64'd20, 64'd3, 5'd7, 64'd6);                               repeat (66) step();
    go(0, 3'b111, 64'd20, 64'd3, 5'd8, 64'd2);                               repeat (66) step();
    go(0, 3'b100, 64'd20, -64'sd3, 5'd9, 64'hFFFF_FFFF_FFFF_FFFA);           repeat (66) step();
    go(0, 3'b110, 64'd20, -64'sd3, 5'd10, 64'd2);                            repeat (66) step();
    go(0, 3'b101, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 5'd11,
       64'h0FFF_FFFF_FFFF_FFFF);                                             repeat (66) step();
    go(0, 3'b101, 64'd5, 64'd0, 5'd12, 64'hFFFF_FFFF_FFFF_FFFF);             repeat (66) step();
    go(0, 3'b110, 64'd5, 64'd0, 5'd13, 64'd5);                               repeat (66) step();
    go(0, 3'b100, 64'h8000_0000_0000_0000, -64'sd1, 5'd14,
       64'h8000_0000_0000_0000);                                             repeat (66) step();
    go(0, 3'b110, 64'h8000_0000_0000_0000, -64'sd1, 5'd15, 64'd0);           repeat (66) step();

    // flush on the tenth CALC cycle: no done, result stays at the previous value
    go(0, 3'b000, 64'd3, 64'd5, 5'd20, 64'd15);
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (3) step();

    // flush together with start in IDLE: start is dropped
    opv[0] = 3'b000; av[0] = 64'd4; bv[0] = 64'd4; rdv[0] = 5'd25;
    st[0] = 1'b1;
    flush = 1'b1;
    step();
    st[0] = 1'b0;
    flush = 1'b0;
    repeat (3) step();

    // a second start mid-CALC must not disturb the op in flight
    go(0, 3'b101, 64'd100, 64'd7, 5'd21, 64'd14);
    repeat (19) step();
    opv[0] = 3'b000; av[0] = 64'd1; bv[0] = 64'd1; rdv[0] = 5'd31;
    st[0] = 1'b1;
    step();
    st[0] = 1'b0;
    repeat (46) step();
    go(0, 3'b111, 64'd100, 64'd7, 5'd22, 64'd2);                             repeat (66) step();

    // reset asserted mid-operation
    go(0, 3'b000, 64'd9, 64'd9, 5'd23, 64'd81);
    repeat (29) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    go(0, 3'b000, 64'd2, 64'd3, 5'd24, 64'd6);                               repeat (66) step();

    go(1, 3'b000, 64'h1_0000, 64'h1_0000, 5'd1, 64'd0);                      repeat (34) step();
    go(1, 3'b011, 64'h1_0000, 64'h1_0000, 5'd2, 64'd1);                      repeat (34) step();
    go(1, 3'b100, 64'd100, 64'hFFFF_FFF9, 5'd3, 64'hFFFF_FFF2);              repeat (34) step();
    go(1, 3'b110, 64'd100, 64'hFFFF_FFF9, 5'd4, 64'd2);                      repeat (34) step();
    go(1, 3'b001, 64'hFFFF_FFFF, 64'h0000_0002, 5'd5, 64'hFFFF_FFFF);        repeat (34) step();

    repeat (4) step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
